alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 65 ++++++
 rtl/alu_seq_decode.sv | 34 +++
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared states, opcode/ALU codes and IR field positions for alu_sequencer
package alu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_BINARY  = 3'd0,
    CLS_UNARY   = 3'd1,
    CLS_MULDIV  = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01000;
  localparam logic [4:0] OPC_ROR  = 5'b01001;
  localparam logic [4:0] OPC_ROL  = 5'b01010;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_HALT = 5'b11010;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1010;
  localparam logic [3:0] ALU_SHR  = 4'b0101;
  localparam logic [3:0] ALU_SHL  = 4'b0110;
  localparam logic [3:0] ALU_ROR  = 4'b0111;
  localparam logic [3:0] ALU_ROL  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1110;
  localparam logic [3:0] ALU_DIV  = 4'b1111;
  localparam logic [3:0] ALU_NEG  = 4'b1100;
  localparam logic [3:0] ALU_NOT  = 4'b1101;

  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode -> instruction class and ALU code
// MULDIV_EN: when defined, mul/div decode as CLS_MULDIV; otherwise they are illegal.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [3:0] operation
);

  always_comb begin
    op_class  = CLS_ILLEGAL;
    operation = ALU_NONE;
    case (opcode)
      OPC_ADD:  begin op_class = CLS_BINARY; operation = ALU_ADD; end
      OPC_SUB:  begin op_class = CLS_BINARY; operation = ALU_SUB; end
      OPC_AND:  begin op_class = CLS_BINARY; operation = ALU_AND; end
      OPC_OR:   begin op_class = CLS_BINARY; operation = ALU_OR;  end
      OPC_SHR:  begin op_class = CLS_BINARY; operation = ALU_SHR; end
      OPC_SHL:  begin op_class = CLS_BINARY; operation = ALU_SHL; end
      OPC_ROR:  begin op_class = CLS_BINARY; operation = ALU_ROR; end
      OPC_ROL:  begin op_class = CLS_BINARY; operation = ALU_ROL; end
      OPC_NEG:  begin op_class = CLS_UNARY;  operation = ALU_NEG; end
      OPC_NOT:  begin op_class = CLS_UNARY;  operation = ALU_NOT; end
`ifdef MULDIV_EN
      OPC_MUL:  begin op_class = CLS_MULDIV; operation = ALU_MUL; end
      OPC_DIV:  begin op_class = CLS_MULDIV; operation = ALU_DIV; end
`endif
      OPC_HALT: op_class = CLS_HALT;
      default:  op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/execute control sequencer driving datapath strobes
// MULDIV_EN: when defined, enables the four-step mul/div sequence through T6.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin_low,
  output logic        Zin_high,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [3:0]  operation,
  output logic        busy,
  output logic        illegal,
  output logic        halted
);

  state_t     state, state_nxt;
  logic       t1_first;
  op_class_t  op_class;
  logic [3:0] alu_op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir_bits;

  assign ra = IR[RA_MSB:RA_LSB];
  assign rb = IR[RB_MSB:RB_LSB];
  assign rc = IR[RC_MSB:RC_LSB];
  assign unused_ir_bits = ^IR[RC_LSB-1:0];

  alu_seq_decode u_decode (
    .opcode    (IR[OPC_MSB:OPC_LSB]),
    .op_class  (op_class),
    .operation (alu_op)
  );

  // t1_first marks the single T1 cycle that loads the incremented PC
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      t1_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      t1_first <= (state == S_T0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = run ? S_T0 : S_IDLE;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = mem_rdy ? S_T2 : S_T1;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        case (op_class)
          CLS_HALT:    state_nxt = S_HALT;
          CLS_ILLEGAL: state_nxt = run ? S_T0 : S_IDLE;
          default:     state_nxt = S_T4;
        endcase
      end
      S_T4: state_nxt = (op_class == CLS_UNARY) ? (run ? S_T0 : S_IDLE) : S_T5;
`ifdef MULDIV_EN
      S_T5: state_nxt = (op_class == CLS_MULDIV) ? S_T6 : (run ? S_T0 : S_IDLE);
      S_T6: state_nxt = run ? S_T0 : S_IDLE;
`else
      S_T5: state_nxt = run ? S_T0 : S_IDLE;
`endif
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    PCout     = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin_low   = 1'b0;
    Zin_high  = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Rout      = 16'h0000;
    Rin       = 16'h0000;
    operation = ALU_NONE;
    illegal   = 1'b0;
    busy      = (state != S_IDLE) && (state != S_HALT);
    halted    = (state == S_HALT);
    case (state)
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin_low = 1'b1;
      end
      S_T1: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        Zlowout = t1_first;
        PCin    = t1_first;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (op_class)
          CLS_BINARY, CLS_MULDIV: begin
            Rout = reg_onehot(rb);
            Yin  = 1'b1;
          end
          CLS_UNARY: begin
            Rout      = reg_onehot(rb);
            operation = alu_op;
            Zin_low   = 1'b1;
          end
          CLS_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        if (op_class == CLS_UNARY) begin
          Zlowout = 1'b1;
          Rin     = reg_onehot(ra);
        end else begin
          Rout      = reg_onehot(rc);
          operation = alu_op;
          Zin_low   = 1'b1;
          Zin_high  = (op_class == CLS_MULDIV);
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_class == CLS_MULDIV) LOin = 1'b1;
        else                        Rin  = reg_onehot(ra);
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer against a cycle-list model
// MULDIV_EN: when defined, the model expects the mul/div sequence instead of illegal.
module tb_alu_sequencer;

  logic        Clock, clear, run, mem_rdy;
  logic [31:0] IR;
  logic        PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        Zin_low, Zin_high, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] Rout, Rin;
  logic [3:0]  operation;
  logic        busy, illegal, halted;

  typedef struct packed {
    logic pc_out, inc_pc, mar_in, pc_in, rd, mdr_in, mdr_out, ir_in, y_in;
    logic z_in_low, z_in_high, z_low_out, z_high_out, hi_in, lo_in;
    logic [15:0] r_out, r_in;
    logic [3:0]  op;
    logic bsy, ill, hlt;
  } obs_t;

  obs_t obs;
  int checks = 0;
  int failures = 0;

  assign obs = obs_t'({PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin, Yin,
                       Zin_low, Zin_high, Zlowout, Zhighout, HIin, LOin,
                       Rout, Rin, operation, busy, illegal, halted});

  alu_sequencer dut (
    .Clock(Clock), .clear(clear), .run(run), .mem_rdy(mem_rdy), .IR(IR),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin_low(Zin_low),
    .Zin_high(Zin_high), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
    .LOin(LOin), .Rout(Rout), .Rin(Rin), .operation(operation), .busy(busy),
    .illegal(illegal), .halted(halted)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Classes: 0 binary, 1 unary, 2 mul/div, 3 halt, 4 illegal
  function automatic int model_class(input logic [4:0] opc);
    case (opc)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: return 0;
      5'b10001, 5'b10010: return 1;
`ifdef MULDIV_EN
      5'b01111, 5'b10000: return 2;
`endif
      5'b11010: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_alu(input logic [4:0] opc);
    case (opc)
      5'b00011: return 4'b0011;
      5'b00100: return 4'b0100;
      5'b00101: return 4'b1011;
      5'b00110: return 4'b1010;
      5'b00111: return 4'b0101;
      5'b01000: return 4'b0110;
      5'b01001: return 4'b0111;
      5'b01010: return 4'b1000;
      5'b01111: return 4'b1110;
      5'b10000: return 4'b1111;
      5'b10001: return 4'b1100;
      5'b10010: return 4'b1101;
      default:  return 4'b0000;
    endcase
  endfunction

  // Compare the current cycle, then present mem_rdy for the next edge
  task automatic cyc(input string tag, input obs_t e, input logic mrdy);
    check(tag, obs, e);
    mem_rdy = mrdy;
    @(posedge Clock);
    #1;
  endtask

  task automatic exec_instr(input logic [31:0] ir, input int waits, input logic run_end);
    obs_t e;
    int cls;
    logic [3:0] alu;
    cls = model_class(ir[31:27]);
    alu = model_alu(ir[31:27]);
    IR = ir;
    e = '0; e.bsy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in_low = 1;
    cyc("t0", e, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      e = '0; e.bsy = 1; e.rd = 1; e.mdr_in = 1;
      if (i == 0) begin e.pc_in = 1; e.z_low_out = 1; end
      cyc(i == 0 ? "t1_first" : "t1_wait", e, i == waits);
    end
    run = run_end;
    e = '0; e.bsy = 1; e.mdr_out = 1; e.ir_in = 1;
    cyc("t2", e, 1'b0);
    e = '0; e.bsy = 1;
    case (cls)
      0, 2: begin
        e.r_out = 16'(1) << ir[22:19]; e.y_in = 1;
        cyc("t3_bin", e, 1'b0);
        e = '0; e.bsy = 1; e.r_out = 16'(1) << ir[18:15]; e.op = alu; e.z_in_low = 1;
        e.z_in_high = (cls == 2);
        cyc("t4_bin", e, 1'b0);
        e = '0; e.bsy = 1; e.z_low_out = 1;
        if (cls == 2) e.lo_in = 1; else e.r_in = 16'(1) << ir[26:23];
        cyc("t5", e, 1'b0);
        if (cls == 2) begin
          e = '0; e.bsy = 1; e.z_high_out = 1; e.hi_in = 1;
          cyc("t6", e, 1'b0);
        end
      end
      1: begin
        e.r_out = 16'(1) << ir[22:19]; e.op = alu; e.z_in_low = 1;
        cyc("t3_un", e, 1'b0);
        e = '0; e.bsy = 1; e.z_low_out = 1; e.r_in = 16'(1) << ir[26:23];
        cyc("t4_un", e, 1'b0);
      end
      3: cyc("t3_halt", e, 1'b0);
      default: begin
        e.ill = 1;
        cyc("t3_illegal", e, 1'b0);
      end
    endcase
  endtask

  logic [4:0] legal_ops [13];
  obs_t zero, e;
  logic [31:0] ir;

  initial begin
    legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                  5'b01001, 5'b01010, 5'b10001, 5'b10010, 5'b01111, 5'b10000, 5'b11111};
    zero = '0;
    clear = 1'b0; run = 1'b0; mem_rdy = 1'b0; IR = 32'h0;
    #2;
    check("reset", obs, zero);
    @(posedge Clock); #1;
    clear = 1'b1;
    cyc("idle_hold", zero, 1'b1);
    cyc("idle_hold", zero, 1'b0);
    run = 1'b1;
    cyc("idle_go", zero, 1'b0);

    exec_instr(32'h28918000, 0, 1'b1);
    exec_instr({5'b00011, 4'd4, 4'd5, 4'd6, 15'h0}, 3, 1'b1);
    exec_instr({5'b11111, 4'd1, 4'd2, 4'd3, 15'h0}, 0, 1'b1);
    exec_instr({5'b01111, 4'd1, 4'd2, 4'd3, 15'h0}, 1, 1'b1);
    exec_instr({5'b10000, 4'd7, 4'd8, 4'd9, 15'h0}, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic stop;
      ir = $urandom;
      if ($urandom_range(0, 3) != 0) ir[31:27] = legal_ops[$urandom_range(0, 12)];
      if (ir[31:27] == 5'b11010) ir[31:27] = 5'b10001;
      stop = (n % 8 == 7);
      exec_instr(ir, $urandom_range(0, 3), !stop);
      if (stop) begin
        cyc("idle_stop", zero, 1'b0);
        run = 1'b1;
        cyc("idle_go", zero, 1'b0);
      end
    end

    // Asynchronous clear in the middle of T4
    IR = {5'b00100, 4'd10, 4'd11, 4'd12, 15'h0};
    repeat (4) begin
      mem_rdy = 1'b1;
      @(posedge Clock);
    end
    #1;
    e = '0; e.bsy = 1; e.r_out = 16'h1000; e.op = 4'b0100; e.z_in_low = 1;
    check("t4_before_clear", obs, e);
    #3 clear = 1'b0;
    #1 check("clear_mid_t4", obs, zero);
    @(posedge Clock); #1;
    clear = 1'b1; run = 1'b0;
    cyc("clear_idle", zero, 1'b0);
    run = 1'b1;
    cyc("clear_go", zero, 1'b0);
    exec_instr({5'b01010, 4'd15, 4'd0, 4'd14, 15'h0}, 2, 1'b1);

    exec_instr({5'b11010, 4'd3, 4'd3, 4'd3, 15'h0}, 1, 1'b1);
    e = '0; e.hlt = 1;
    for (int i = 0; i < 10; i++) cyc("halt_hold", e, 1'($urandom_range(0, 1)));
    #3 clear = 1'b0;
    #1 check("clear_halt", obs, zero);
    @(posedge Clock); #1;
    clear = 1'b1; run = 1'b0;
    cyc("post_halt_idle", zero, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
